// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, the "value present" tag and a select-index width helper
// for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned RS_DEPTH_DEF = 8;   // station entries
  localparam int unsigned DATA_W_DEF   = 32;  // operand/data bus width
  localparam int unsigned TAG_W_DEF    = 4;   // rename tag width
  localparam int unsigned NAME_W_DEF   = 5;   // architectural name width
  localparam int unsigned OP_W_DEF     = 5;   // ALU opcode width

  // Tag value meaning "operand value already present, nothing to wait for".
  localparam int unsigned TAG_FREE = 0;

  // Width of a binary index into an n-entry vector (at least one bit).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// rs_select: lowest-index one-hot pick from a request vector, plus its binary
// index and an any-request flag. Used for free-slot allocation and ready pick.
module rs_select
  import alu_rs_pkg::*;
#(
  parameter int unsigned N  = RS_DEPTH_DEF,
  parameter int unsigned IW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Two's complement isolates the lowest set bit.
  assign grant = req & (-req);
  assign any   = |req;

  // Encode the one-hot grant into a binary index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station. Holds dispatched ALU ops, snoops the CDB to wake
// operands and issues the lowest-index ready entry per cycle through a registered
// valid/ready stage. Optional macro RS_WAKEUP_BYPASS_EN lets an entry whose last
// operand(s) arrive on the current CDB broadcast issue in that same cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_DEPTH = RS_DEPTH_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF,
  parameter int unsigned NAME_W   = NAME_W_DEF,
  parameter int unsigned OP_W     = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_q1,
  input  logic [DATA_W-1:0] disp_v1,
  input  logic [TAG_W-1:0]  disp_q2,
  input  logic [DATA_W-1:0] disp_v2,
  input  logic [TAG_W-1:0]  disp_dest_tag,
  input  logic [NAME_W-1:0] disp_dest_name,
  output logic              rs_full,
  input  logic              enCDBWrt,
  input  logic [TAG_W-1:0]  CDBwrtTag,
  input  logic [DATA_W-1:0] CDBwrtData,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [TAG_W-1:0]  alu_tag,
  output logic [NAME_W-1:0] alu_name
);

  localparam int unsigned      IW       = sel_width(RS_DEPTH);
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_FREE);

  // Entry storage: busy bits are reset, payload is only meaningful while busy.
  logic [RS_DEPTH-1:0] busy_reg, busy_next;
  logic [OP_W-1:0]     op_reg   [RS_DEPTH];
  logic [TAG_W-1:0]    q1_reg   [RS_DEPTH];
  logic [DATA_W-1:0]   v1_reg   [RS_DEPTH];
  logic [TAG_W-1:0]    q2_reg   [RS_DEPTH];
  logic [DATA_W-1:0]   v2_reg   [RS_DEPTH];
  logic [TAG_W-1:0]    dtag_reg [RS_DEPTH];
  logic [NAME_W-1:0]   dname_reg[RS_DEPTH];

  // Issue (output) register.
  logic              alu_valid_reg;
  logic [OP_W-1:0]   alu_op_reg;
  logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
  logic [TAG_W-1:0]  alu_tag_reg;
  logic [NAME_W-1:0] alu_name_reg;

  logic [RS_DEPTH-1:0] free_vec, alloc_grant, ready_vec, ready_grant;
  logic [RS_DEPTH-1:0] q1_hit, q2_hit;
  logic [IW-1:0]       alloc_idx, ready_idx;
  logic                alloc_any, ready_any;
  logic                cdb_hit, disp_fire, load_en, issue_fire;
  logic                dq1_hit, dq2_hit;
  logic [DATA_W-1:0]   issue_a, issue_b;

  // A broadcast of the "value present" tag carries no wakeup.
  assign cdb_hit = enCDBWrt && (CDBwrtTag != TAG_NONE);

  // Per-entry CDB match and readiness.
  for (genvar gi = 0; gi < int'(RS_DEPTH); gi++) begin : g_entry
    assign free_vec[gi] = ~busy_reg[gi];
    assign q1_hit[gi]   = cdb_hit && (q1_reg[gi] == CDBwrtTag);
    assign q2_hit[gi]   = cdb_hit && (q2_reg[gi] == CDBwrtTag);
`ifdef RS_WAKEUP_BYPASS_EN
    assign ready_vec[gi] = busy_reg[gi]
                         && ((q1_reg[gi] == TAG_NONE) || q1_hit[gi])
                         && ((q2_reg[gi] == TAG_NONE) || q2_hit[gi]);
`else
    assign ready_vec[gi] = busy_reg[gi]
                         && (q1_reg[gi] == TAG_NONE)
                         && (q2_reg[gi] == TAG_NONE);
`endif
  end

  rs_select #(.N(RS_DEPTH), .IW(IW)) u_alloc (
    .req   (free_vec),
    .grant (alloc_grant),
    .idx   (alloc_idx),
    .any   (alloc_any)
  );

  rs_select #(.N(RS_DEPTH), .IW(IW)) u_pick (
    .req   (ready_vec),
    .grant (ready_grant),
    .idx   (ready_idx),
    .any   (ready_any)
  );

  // Fullness looks only at registered busy bits, so a same-cycle issue never
  // opens a slot for a dispatch.
  assign rs_full    = &busy_reg;
  assign disp_fire  = disp_valid && alloc_any;
  assign load_en    = !alu_valid_reg || alu_ready;
  assign issue_fire = load_en && ready_any;

  // A dispatching operand whose tag is on the CDB right now captures the data.
  assign dq1_hit = cdb_hit && (disp_q1 == CDBwrtTag);
  assign dq2_hit = cdb_hit && (disp_q2 == CDBwrtTag);

  // Next busy vector: drop the issued entry, add the allocated one.
  always_comb begin
    busy_next = busy_reg;
    if (issue_fire) busy_next = busy_next & ~ready_grant;
    if (disp_fire)  busy_next = busy_next | alloc_grant;
  end

  // Busy bits: reset and flush both empty the station.
  always_ff @(posedge clk) begin
    if (rst)        busy_reg <= '0;
    else if (flush) busy_reg <= '0;
    else            busy_reg <= busy_next;
  end

  // Payload: CDB wakeup for waiting entries, then the dispatch write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (busy_reg[i] && q1_hit[i]) begin
        q1_reg[i] <= TAG_NONE;
        v1_reg[i] <= CDBwrtData;
      end
      if (busy_reg[i] && q2_hit[i]) begin
        q2_reg[i] <= TAG_NONE;
        v2_reg[i] <= CDBwrtData;
      end
    end
    if (disp_fire) begin
      op_reg[alloc_idx]    <= disp_op;
      q1_reg[alloc_idx]    <= dq1_hit ? TAG_NONE : disp_q1;
      v1_reg[alloc_idx]    <= dq1_hit ? CDBwrtData : disp_v1;
      q2_reg[alloc_idx]    <= dq2_hit ? TAG_NONE : disp_q2;
      v2_reg[alloc_idx]    <= dq2_hit ? CDBwrtData : disp_v2;
      dtag_reg[alloc_idx]  <= disp_dest_tag;
      dname_reg[alloc_idx] <= disp_dest_name;
    end
  end

  // Operand values for the selected entry (CDB data forwarded when bypassing).
  always_comb begin
    issue_a = v1_reg[ready_idx];
    issue_b = v2_reg[ready_idx];
`ifdef RS_WAKEUP_BYPASS_EN
    if (q1_reg[ready_idx] != TAG_NONE) issue_a = CDBwrtData;
    if (q2_reg[ready_idx] != TAG_NONE) issue_b = CDBwrtData;
`endif
  end

  // Issue register: loads when empty or being consumed, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid_reg <= 1'b0;
      alu_op_reg    <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_tag_reg   <= '0;
      alu_name_reg  <= '0;
    end else if (flush) begin
      alu_valid_reg <= 1'b0;
    end else if (load_en) begin
      alu_valid_reg <= ready_any;
      if (ready_any) begin
        alu_op_reg   <= op_reg[ready_idx];
        alu_a_reg    <= issue_a;
        alu_b_reg    <= issue_b;
        alu_tag_reg  <= dtag_reg[ready_idx];
        alu_name_reg <= dname_reg[ready_idx];
      end
    end
  end

  assign alu_valid = alu_valid_reg;
  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_tag   = alu_tag_reg;
  assign alu_name  = alu_name_reg;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed table, hand-written corner sequences and randomized traffic
// for alu_rs, checked against a behavioural station model every cycle.
module tb_alu_rs;

  localparam int D = 8;

  logic        clk;
  logic        rst, flush, disp_valid, enCDBWrt, alu_ready;
  logic [4:0]  disp_op, disp_dest_name;
  logic [3:0]  disp_q1, disp_q2, disp_dest_tag, CDBwrtTag;
  logic [31:0] disp_v1, disp_v2, CDBwrtData;
  logic        rs_full, alu_valid;
  logic [4:0]  alu_op, alu_name;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_tag;

  int n_tests, n_fail;

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_q1(disp_q1), .disp_v1(disp_v1), .disp_q2(disp_q2), .disp_v2(disp_v2),
    .disp_dest_tag(disp_dest_tag), .disp_dest_name(disp_dest_name),
    .rs_full(rs_full),
    .enCDBWrt(enCDBWrt), .CDBwrtTag(CDBwrtTag), .CDBwrtData(CDBwrtData),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_tag(alu_tag), .alu_name(alu_name)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_busy [D];
  logic [4:0]  m_op   [D];
  logic [3:0]  m_q1   [D], m_q2 [D], m_dt [D];
  logic [31:0] m_v1   [D], m_v2 [D];
  logic [4:0]  m_dn   [D];
  logic        m_av, m_known, m_full;
  logic [4:0]  m_aop, m_aname;
  logic [31:0] m_aa, m_ab;
  logic [3:0]  m_atag;

  function automatic logic op_ok(input logic [3:0] q, input logic cdb, input logic [3:0] ct);
`ifdef RS_WAKEUP_BYPASS_EN
    return (q == 0) || (cdb && q == ct);
`else
    return (q == 0);
`endif
  endfunction

  task automatic model_step();
    int rd, fr;
    logic full, cdb;
    if (rst) begin
      for (int i = 0; i < D; i++) m_busy[i] = 0;
      m_av = 0; m_known = 1;
      m_aop = 0; m_aa = 0; m_ab = 0; m_atag = 0; m_aname = 0;
    end else if (flush) begin
      for (int i = 0; i < D; i++) m_busy[i] = 0;
      m_av = 0; m_known = 0;
    end else begin
      full = 1;
      fr = -1;
      for (int i = 0; i < D; i++)
        if (!m_busy[i]) begin
          full = 0;
          if (fr < 0) fr = i;
        end
      cdb = enCDBWrt && (CDBwrtTag != 0);
      rd = -1;
      for (int i = 0; i < D; i++)
        if (rd < 0 && m_busy[i] && op_ok(m_q1[i], cdb, CDBwrtTag) && op_ok(m_q2[i], cdb, CDBwrtTag))
          rd = i;
      if (!m_av || alu_ready) begin
        if (rd >= 0) begin
          m_av = 1; m_known = 1;
          m_aop = m_op[rd]; m_atag = m_dt[rd]; m_aname = m_dn[rd];
          m_aa = (m_q1[rd] == 0) ? m_v1[rd] : CDBwrtData;
          m_ab = (m_q2[rd] == 0) ? m_v2[rd] : CDBwrtData;
          m_busy[rd] = 0;
        end else begin
          m_av = 0;
        end
      end
      for (int i = 0; i < D; i++)
        if (m_busy[i] && cdb) begin
          if (m_q1[i] == CDBwrtTag) begin m_q1[i] = 0; m_v1[i] = CDBwrtData; end
          if (m_q2[i] == CDBwrtTag) begin m_q2[i] = 0; m_v2[i] = CDBwrtData; end
        end
      if (disp_valid && !full) begin
        m_busy[fr] = 1;
        m_op[fr] = disp_op; m_dt[fr] = disp_dest_tag; m_dn[fr] = disp_dest_name;
        if (cdb && disp_q1 == CDBwrtTag) begin m_q1[fr] = 0; m_v1[fr] = CDBwrtData; end
        else begin m_q1[fr] = disp_q1; m_v1[fr] = disp_v1; end
        if (cdb && disp_q2 == CDBwrtTag) begin m_q2[fr] = 0; m_v2[fr] = CDBwrtData; end
        else begin m_q2[fr] = disp_q2; m_v2[fr] = disp_v2; end
      end
    end
    m_full = 1;
    for (int i = 0; i < D; i++) if (!m_busy[i]) m_full = 0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model_valid", 32'(alu_valid), 32'(m_av));
    chk("model_full", 32'(rs_full), 32'(m_full));
    if (m_av || m_known) begin
      chk("model_op", 32'(alu_op), 32'(m_aop));
      chk("model_a", alu_a, m_aa);
      chk("model_b", alu_b, m_ab);
      chk("model_tag", 32'(alu_tag), 32'(m_atag));
      chk("model_name", 32'(alu_name), 32'(m_aname));
    end
  endtask

  // One clock: advance the model with the current inputs, clock, check after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; enCDBWrt = 0;
    disp_op = 0; disp_q1 = 0; disp_v1 = 0; disp_q2 = 0; disp_v2 = 0;
    disp_dest_tag = 0; disp_dest_name = 0; CDBwrtTag = 0; CDBwrtData = 0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [3:0] q1, input logic [31:0] v1,
                      input logic [3:0] q2, input logic [31:0] v2,
                      input logic [3:0] dt, input logic [4:0] dn);
    disp_valid = 1; disp_op = op; disp_q1 = q1; disp_v1 = v1; disp_q2 = q2; disp_v2 = v2;
    disp_dest_tag = dt; disp_dest_name = dn;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        dv;
    logic [4:0]  op;
    logic [3:0]  q1;
    logic [31:0] v1;
    logic [3:0]  q2;
    logic [31:0] v2;
    logic [3:0]  dt;
    logic [4:0]  dn;
    logic        ce;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        ev;
    logic [4:0]  eop;
    logic [31:0] ea, eb;
    logic [3:0]  etag;
    logic [4:0]  ename;
  } vec_t;

  function automatic vec_t mk(input logic dv, input logic [4:0] op, input logic [3:0] q1,
                              input logic [31:0] v1, input logic [3:0] q2, input logic [31:0] v2,
                              input logic [3:0] dt, input logic [4:0] dn,
                              input logic ce, input logic [3:0] ct, input logic [31:0] cd,
                              input logic ev, input logic [4:0] eop, input logic [31:0] ea,
                              input logic [31:0] eb, input logic [3:0] etag, input logic [4:0] ename);
    vec_t v;
    v.dv = dv; v.op = op; v.q1 = q1; v.v1 = v1; v.q2 = q2; v.v2 = v2; v.dt = dt; v.dn = dn;
    v.ce = ce; v.ct = ct; v.cd = cd;
    v.ev = ev; v.eop = eop; v.ea = ea; v.eb = eb; v.etag = etag; v.ename = ename;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < D; i++) m_busy[i] = 0;
    m_av = 0; m_known = 0; m_full = 0;
    idle();
    alu_ready = 1;
    rst = 1;
    step();
    step();
    rst = 0;

    // Ready dispatch -> valid two edges later; dispatch capturing CDB tag 9;
    // tag-0 broadcast ignored; CDB wakeup of q1=4 with 0xDEAD.
    tbl[0]  = mk(1, 3, 0, 5,      0, 7, 1, 2,  0, 0, 0,           0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,           1, 3, 5, 7, 1, 2);
    tbl[2]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,           0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 4, 0, 32'h11, 9, 0, 2, 3,  1, 9, 32'hBEEF,    0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,           1, 4, 32'h11, 32'hBEEF, 2, 3);
    tbl[5]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,           0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 5, 4, 0,      0, 1, 3, 4,  0, 0, 0,           0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  1, 0, 32'h55,      0, 0, 0, 0, 0, 0);
`ifdef RS_WAKEUP_BYPASS_EN
    tbl[8]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  1, 4, 32'hDEAD,    1, 5, 32'hDEAD, 1, 3, 4);
    tbl[9]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,           0, 0, 0, 0, 0, 0);
`else
    tbl[8]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  1, 4, 32'hDEAD,    0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,           1, 5, 32'hDEAD, 1, 3, 4);
`endif
    tbl[10] = mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,           0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      idle();
      disp_valid = tbl[i].dv; disp_op = tbl[i].op;
      disp_q1 = tbl[i].q1; disp_v1 = tbl[i].v1; disp_q2 = tbl[i].q2; disp_v2 = tbl[i].v2;
      disp_dest_tag = tbl[i].dt; disp_dest_name = tbl[i].dn;
      enCDBWrt = tbl[i].ce; CDBwrtTag = tbl[i].ct; CDBwrtData = tbl[i].cd;
      step();
      $display("[TB] table row %0d: alu_valid=%0d alu_a=%h alu_b=%h", i, alu_valid, alu_a, alu_b);
      chk("tbl_valid", 32'(alu_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl_op", 32'(alu_op), 32'(tbl[i].eop));
        chk("tbl_a", alu_a, tbl[i].ea);
        chk("tbl_b", alu_b, tbl[i].eb);
        chk("tbl_tag", 32'(alu_tag), 32'(tbl[i].etag));
        chk("tbl_name", 32'(alu_name), 32'(tbl[i].ename));
      end
    end

    // Full station and backpressure: 8 entries waiting on tag 6, 9th dropped.
    idle();
    alu_ready = 0;
    for (int i = 0; i < D; i++) begin
      disp(5'(i), 4'd6, 0, 4'd0, 32'(i), 4'(i + 1), 5'(i));
      step();
    end
    chk("bp_full_after_fill", 32'(rs_full), 1);
    disp(5'd9, 4'd6, 0, 4'd0, 32'h99, 4'd15, 5'd31);
    step();
    chk("bp_full_after_drop", 32'(rs_full), 1);
    chk("bp_no_issue", 32'(alu_valid), 0);
    idle();
    enCDBWrt = 1; CDBwrtTag = 6; CDBwrtData = 32'hA0;
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      $display("[TB] stall cycle %0d: alu_valid=%0d alu_tag=%0d", k, alu_valid, alu_tag);
      chk("bp_hold_valid", 32'(alu_valid), 1);
      chk("bp_hold_tag", 32'(alu_tag), 1);
      chk("bp_hold_a", alu_a, 32'hA0);
    end
    alu_ready = 1;
    for (int k = 0; k < D; k++) begin
      $display("[TB] drain %0d: alu_valid=%0d alu_tag=%0d alu_b=%0h", k, alu_valid, alu_tag, alu_b);
      chk("drain_valid", 32'(alu_valid), 1);
      chk("drain_tag", 32'(alu_tag), 32'(k + 1));
      chk("drain_b", alu_b, 32'(k));
      step();
    end
    chk("drain_empty", 32'(alu_valid), 0);

    // Flush with 3 busy entries, a valid issue register and a simultaneous dispatch.
    alu_ready = 0;
    for (int i = 0; i < 4; i++) begin
      disp(5'd1, 0, 32'(i), 0, 32'(i), 4'(i + 1), 5'(i));
      step();
    end
    idle();
    step();
    chk("fl_pre_valid", 32'(alu_valid), 1);
    flush = 1;
    disp(5'd2, 0, 32'h77, 0, 32'h88, 4'd9, 5'd9);
    step();
    $display("[TB] after flush: alu_valid=%0d rs_full=%0d", alu_valid, rs_full);
    chk("fl_valid", 32'(alu_valid), 0);
    chk("fl_full", 32'(rs_full), 0);
    idle();
    alu_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fl_quiet", 32'(alu_valid), 0);
    end

    // Reset mid-traffic for two cycles.
    alu_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(5'd7, 0, 32'h100 + 32'(i), 0, 32'h200, 4'(i + 3), 5'(i + 3));
      step();
    end
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    $display("[TB] after reset: alu_valid=%0d alu_a=%h rs_full=%0d", alu_valid, alu_a, rs_full);
    chk("rst_valid", 32'(alu_valid), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_op", 32'(alu_op), 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_tag", 32'(alu_tag), 0);
    chk("rst_name", 32'(alu_name), 0);
    alu_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_quiet", 32'(alu_valid), 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      idle();
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 99) == 0);
      alu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        disp(5'($urandom), ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 7)),
             $urandom, ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 7)),
             $urandom, 4'($urandom), 5'($urandom));
      enCDBWrt   = ($urandom_range(0, 1) == 1);
      CDBwrtTag  = 4'($urandom_range(0, 7));
      CDBwrtData = $urandom;
      step();
      if (alu_valid && alu_ready)
        $display("[TB] rnd %0d: issue op=%0d a=%h b=%h tag=%0d", c, alu_op, alu_a, alu_b, alu_tag);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- ALU reservation station, directly upstream of the ROB write port.
- Holds dispatched ALU instructions and snoops the CDB (enCDBWrt/CDBwrtTag/CDBwrtData) to wake waiting operands.
- Issues one operand-ready instruction per cycle to the ALU through a registered valid/ready output stage.
- The ALU result then enters the ROB via ROBenW/ROBtagW/ROBdataW/ROBnameW.

Parameters:
- RS_DEPTH, 8, number of entries (power of two, ≥2).
- DATA_W, 32, operand/data width (matches `DataBus).
- TAG_W, 4, rename tag width (matches `TagBus); tag 0 is `tagFree, meaning "value present".
- NAME_W, 5, architectural destination name width (matches `NameBus).
- OP_W, 5, ALU opcode width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  misprediction flush; discards all entries and the issue register.
- disp_valid  in  1  dispatch request this cycle.
- disp_op  in  OP_W  opcode.
- disp_q1  in  TAG_W  src1 tag; 0 means disp_v1 is valid.
- disp_v1  in  DATA_W  src1 value.
- disp_q2  in  TAG_W  src2 tag.
- disp_v2  in  DATA_W  src2 value.
- disp_dest_tag  in  TAG_W  destination rename tag.
- disp_dest_name  in  NAME_W  destination register name.
- rs_full  out  1  all entries busy; dispatch is refused.
- enCDBWrt  in  1  CDB broadcast valid.
- CDBwrtTag  in  TAG_W  broadcast tag.
- CDBwrtData  in  DATA_W  broadcast data.
- alu_valid  out  1  issue register holds an instruction.
- alu_ready  in  1  ALU accepts this cycle.
- alu_op  out  OP_W  issued opcode.
- alu_a  out  DATA_W  issued src1 value.
- alu_b  out  DATA_W  issued src2 value.
- alu_tag  out  TAG_W  issued destination tag.
- alu_name  out  NAME_W  issued destination name.

Behaviour:
- Entry state: busy, op, q1, v1, q2, v2, dest_tag, dest_name.
- An entry is ready when busy, q1 == 0 and q2 == 0.
- Reset (rst high at posedge): all busy bits cleared, alu_valid = 0, alu_op/alu_a/alu_b/alu_tag/alu_name = 0. rs_full reads 0 in the following cycle. Reset mid-operation discards everything, with no partial issue.
- Precedence: rst > flush > normal operation.
- flush: same effect as reset on busy bits and alu_valid; payload outputs are don't-care. A dispatch in the flush cycle is dropped.
- rs_full: combinational from registered busy bits only (all busy).
- Dispatch: accepted when disp_valid && !rs_full. It writes the lowest-index free entry (free & -free one-hot) and sets busy at the next posedge. Dispatch while rs_full is silently ignored. An entry freed by issue in the same cycle does not make a full station accept.
- Wakeup: when enCDBWrt && CDBwrtTag != 0, every busy entry with qN == CDBwrtTag sets vN = CDBwrtData and qN = 0.
  - A dispatching instruction whose disp_qN equals CDBwrtTag in the same cycle captures the CDB data instead of storing the tag. This is mandatory; there is no lost wakeup.
  - A CDB broadcast with tag 0 is ignored.
- Issue register load: loads when !alu_valid || alu_ready, i.e. the output is empty or being consumed.
  - Select the lowest-index ready entry (ready & -ready).
  - Copy it to the alu_* outputs, set alu_valid = 1, and clear that entry's busy bit at the same posedge.
  - With no ready entry: alu_valid becomes 0 if it was consumed, otherwise it holds.
- Handshake: while alu_valid && !alu_ready, all alu_* outputs hold stable and no entry is removed.
- Latency (base build):
  - Dispatch with both tags 0 in cycle N: entry busy at N+1, alu_valid at N+2.
  - Last operand woken by CDB in cycle N: alu_valid at N+2.
- Throughput: one issue per cycle with alu_ready held high.

Optional Feature:
- Macro: RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry whose only outstanding operand(s) match the current CDB broadcast counts as ready in cycle N.
  - Its CDB data is muxed directly into alu_a/alu_b, giving alu_valid at N+1.
  - Priority is still lowest index among all ready entries, bypassed or not.
  - Dispatch-cycle entries are not bypass-eligible.
- Undefined: wakeup-to-issue latency is N+2 as above.

Decomposition:
- Shared defines file holds `DataBus, `TagBus, `NameBus, `OpBus, `tagFree (0) and `RSsize.
- Sub-module rs_select: parameterised lowest-index one-hot pick plus binary index plus any-valid. Instantiated twice: free-slot allocation and ready selection.

Test Plan:
- Reset: assert rst for 2 cycles mid-traffic → alu_valid=0, all alu_* outputs 0, rs_full=0; previously busy entries never issue.
- Ready dispatch: op=3, v1=5, v2=7, both tags 0, dispatched at cycle 0, alu_ready=1 → alu_valid=1 at cycle 2 with alu_a=5, alu_b=7, alu_tag/alu_name as dispatched; alu_valid=0 at cycle 3.
- Wakeup: entry with q1=4 waits; CDB tag=4, data=0xDEAD at cycle 5 → alu_a=0xDEAD, alu_valid=1 at cycle 7, or at cycle 6 with RS_WAKEUP_BYPASS_EN. Dispatch with q2=9 coinciding with CDB tag 9 → issues with the CDB data.
- Full/backpressure: fill 8 entries with tags waiting on 6 → rs_full=1 and a 9th dispatch is dropped. Hold alu_ready=0 and broadcast tag 6 → alu_* stable; then release alu_ready → entries 0..7 issue on consecutive cycles in index order.
- Flush: flush with 3 busy entries and alu_valid=1 plus a simultaneous dispatch → next cycle alu_valid=0, rs_full=0, nothing issues afterwards.
